// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types for the instruction fetch controller: FSM states, fault codes,
// bus widths and the {pc, instr} queue entry.
package imem_fetch_ctrl_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_HALT  = 2'd2,
    FETCH_FAULT = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_RANGE    = 2'd2
  } fault_code_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_queue.sv
// 2-entry FIFO of fetched {pc, instr}; head visible combinationally.
// Latency: push at edge t is at the head after t. Push+pop in one cycle legal.
// Backpressure: none internal; the producer must respect count (overflow asserts).
module fetch_queue
  import imem_fetch_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic         head_valid,
  output fetch_entry_t head_data,
  output logic [1:0]   count
);

  fetch_entry_t slots [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count_q;
  logic         do_pop;

  assign do_pop     = pop && (count_q != 2'd0);
  assign head_valid = (count_q != 2'd0);
  assign head_data  = head_valid ? slots[rd_ptr] : '0;
  assign count      = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++) slots[i] <= '0;
    end else if (flush) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        slots[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count_q <= count_q + {1'b0, push} - {1'b0, do_pop};
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !flush && !do_pop && count_q == 2'd2));

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, issues one address per cycle to a 1-cycle memory.
// Latency: issue at t -> out_valid at t+2; 1 instr/cycle with out_ready high.
// Backpressure: credit of 2 (queued + in flight) stops issue so decode stalls never drop data.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          MEM_SIZE = 4095
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [ADDR_W-1:0]  fault_pc,
  output logic [1:0]         state
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_SIZE - 4);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              inflight_q;
  logic              fault_q;
  fault_code_t       fault_code_q;
  logic [ADDR_W-1:0] fault_pc_q;

  logic              q_valid;
  logic              q_push;
  logic              q_pop;
  logic [1:0]        q_count;
  fetch_entry_t      q_head;
  fetch_entry_t      q_in;

  logic [2:0]        credit_used;
  logic              credit_ok;
  logic              in_range;
  logic              misalign;
  logic              range_fault;
  logic              issue;

  assign in_range    = (pc_q <= LAST_PC);
  assign misalign    = (redirect_pc[1:0] != 2'b00);
  assign q_pop       = q_valid && out_ready;
  // A head popped this cycle frees its slot in time for the word issued now.
  assign credit_used = {1'b0, q_count} + {2'b00, inflight_q} - {2'b00, q_pop};
  assign credit_ok   = (credit_used < 3'd2);
  assign issue       = (state_q == FETCH_RUN) && !halt_req && !redirect_valid
                       && in_range && credit_ok;
  assign range_fault = (state_q == FETCH_RUN) && !redirect_valid && !in_range;
  assign q_push      = inflight_q && !redirect_valid;
  assign q_in        = {inflight_pc_q, imem_instr};

  fetch_queue u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (q_push),
    .push_data  (q_in),
    .pop        (q_pop),
    .head_valid (q_valid),
    .head_data  (q_head),
    .count      (q_count)
  );

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = misalign ? FETCH_FAULT : FETCH_RUN;
    end else begin
      case (state_q)
        FETCH_BOOT:  state_d = FETCH_RUN;
        FETCH_RUN: begin
          if (!in_range)     state_d = FETCH_FAULT;
          else if (halt_req) state_d = FETCH_HALT;
        end
        FETCH_HALT:  if (!halt_req) state_d = FETCH_RUN;
        FETCH_FAULT: state_d = FETCH_FAULT;
        default:     state_d = FETCH_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH_BOOT;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fault_q       <= 1'b0;
      fault_code_q  <= FAULT_NONE;
      fault_pc_q    <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + ADDR_W'(4);
      end
      if (redirect_valid) begin
        if (misalign) begin
          fault_q      <= 1'b1;
          fault_code_q <= FAULT_MISALIGN;
          fault_pc_q   <= redirect_pc;
        end else begin
          pc_q         <= redirect_pc;
          fault_q      <= 1'b0;
          fault_code_q <= FAULT_NONE;
          fault_pc_q   <= '0;
        end
      end else if (range_fault) begin
        fault_q      <= 1'b1;
        fault_code_q <= FAULT_RANGE;
        fault_pc_q   <= pc_q;
      end
    end
  end

  assign imem_addr  = pc_q;
  assign out_valid  = q_valid;
  assign out_instr  = q_head.instr;
  assign out_pc     = q_head.pc;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign fault_pc   = fault_pc_q;
  assign state      = state_q;

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Fetch controller that sequences the byte-addressed, big-endian instruction memory.
- That memory has a 1-cycle registered read, no enable and an asynchronous reset.
- This block owns the PC, issues one address per cycle and tracks the in-flight read. It buffers returned words in a 2-entry queue so downstream stalls never lose data, and handles redirects (branch/jump), halts, misaligned and out-of-range faults.
- Sits between the instruction memory and the decode stage.

Parameters:
- RESET_PC, 64'h0, PC loaded on reset.
- MEM_SIZE, 4095, instruction memory size in bytes; legal fetch iff pc <= MEM_SIZE-4.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- imem_addr  output  64  byte address driven to the instruction memory.
- imem_instr  input  32  memory read data; valid the cycle after the address was sampled.
- redirect_valid  input  1  single-cycle pulse: flush and restart at redirect_pc.
- redirect_pc  input  64  new fetch address.
- halt_req  input  1  level: stop issuing while high.
- out_valid  output  1  instruction available at queue head.
- out_ready  input  1  decode accepts; transfer when out_valid && out_ready.
- out_instr  output  32  instruction word.
- out_pc  output  64  PC of out_instr.
- fault  output  1  sticky until next redirect or reset.
- fault_code  output  2  0 none, 1 misaligned, 2 out of range.
- fault_pc  output  64  offending PC.
- state  output  2  FSM state, for debug.

Behaviour:
- Reset (async): pc=RESET_PC, state=BOOT, queue empty, inflight_q=0, out_valid=0, fault=0, fault_code=0, fault_pc=0. imem_addr=RESET_PC.
- FSM states: BOOT=0, RUN=1, HALT=2, FAULT=3.
  - BOOT lasts exactly one cycle, so the memory's post-reset zero output is never captured; then RUN.
- imem_addr = pc (combinational from register) in every state.
- Issue condition in cycle t:
  - state==RUN, !halt_req, !redirect_valid, pc <= MEM_SIZE-4;
  - and count - pop < 2, where count = queue_count + inflight_q and pop = out_valid && out_ready.
  - On issue: inflight_q<=1, inflight_pc<=pc, pc<=pc+4. Otherwise inflight_q<=0.
- Capture: in cycle t+1, if inflight_q && !redirect_valid, push {inflight_pc, imem_instr} into the queue.
  - Push and pop in the same cycle are both legal.
  - The credit rule guarantees no overflow; an overflow is an assertion failure.
- Latency: issue at t -> out_valid at t+2. With out_ready held high, throughput is 1 instruction/cycle.
  - First out_valid is the 4th cycle after reset deassertion (BOOT, issue, capture, valid).
- Queue: 2 entries, FIFO order; head drives out_instr/out_pc. out_instr=0 and out_pc=0 when empty.
- Redirect (highest priority, any state except during reset):
  - flush queue, inflight_q<=0, clear fault.
  - If redirect_pc[1:0]!=0: state<=FAULT, fault_code=1, fault_pc=redirect_pc, pc unchanged.
  - Else pc<=redirect_pc, state<=RUN.
  - A coincident handshake is treated as consumed; the queue is flushed regardless.
  - out_valid=0 the cycle after redirect.
- Out of range: in RUN with pc > MEM_SIZE-4 -> state<=FAULT, fault=1, code=2, fault_pc=pc, no issue.
  - Entries already queued or in flight still drain to out.
- FAULT: no issue; leave only on redirect or reset.
- HALT:
  - RUN with halt_req -> HALT. Queue and in-flight data drain normally.
  - HALT with !halt_req -> RUN, resuming at the held pc.
  - A redirect in HALT updates pc and goes to RUN, but issue waits until halt_req is low.
- PC arithmetic: 64-bit, wraps modulo 2^64; wrap is unreachable because the range check fires first.

Decomposition:
- Shared package holds:
  - state encodings FETCH_BOOT/RUN/HALT/FAULT;
  - fault codes FAULT_NONE/MISALIGN/RANGE;
  - INSTR_W=32, ADDR_W=64.
- One sub-module, fetch_queue: 2-entry FIFO of {pc, instr} with push, pop, flush, count outputs.

Test Plan:
- Reset release, out_ready=1, memory bytes 0..11 = 00 00 00 13, 00 10 00 93, 00 20 01 13 -> out_valid from 4th cycle; out_instr 32'h00000013, 32'h00100093, 32'h00200113 on consecutive cycles; out_pc 0, 4, 8.
- out_ready=0 for 5 cycles after the first valid -> queue holds PCs 0 and 4; imem_addr holds 8 with no issue. Release -> outputs 0, 4, 8 in order, none lost or duplicated.
- redirect_valid with redirect_pc=0x40 while two entries are queued -> queue flushed; out_valid=0 next cycle; next delivered out_pc=0x40, 2 cycles after the first issue at 0x40.
- redirect_pc=0x42 -> fault=1, code=1, fault_pc=0x42, no further issue. Then redirect to 0x0 -> fault clears, fetch resumes at 0.
- redirect_pc=4088 -> instruction at 4088 delivered; next cycle fault=1, code=2, fault_pc=4092; imem_addr stays 4092.
- reset asserted mid-stream with 2 entries queued -> out_valid=0 and pc=RESET_PC immediately; after release the first out_pc=RESET_PC, never the stale zero word.
